mc_controller: RTL
==================

# mc_controller

- Multicycle control unit for the RV32I subset (lw, sw, R-type, I-type ALU, beq, jal).
- Moore FSM plus combinational ALU/immediate decode.
- Drives datapath enables and muxes, including `adr_src`, which selects the unified memory address (0 = PC, 1 = ALU result).
- Sits directly upstream of the unified memory and instruction register; consumes the fetched instruction fields and the ALU `zero` flag.

## Interface
- No parameters. State and ALU encodings are fixed constants (see Structure).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `op`  in  7  instr[6:0] from instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`  in  1  ALU zero flag.
- `pc_write`  out  1  PC load enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  unified memory write enable.
- `ir_write`  out  1  instruction register / OldPC load enable.
- `reg_write`  out  1  register file write enable.
- `result_src`  out  2  result mux: 00 = ALUOut, 01 = mem data, 10 = ALU result.
- `alu_src_a`  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = RD1.
- `alu_src_b`  out  2  ALU B mux: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control`  out  3  ALU op: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `illegal`  out  1  sticky, high in the ILLEGAL state.
- `state`  out  4  current state encoding, for debug.

## Operation
States and encodings, with outputs not listed at 0 or don't-care (`aluop`: 00 = add, 01 = sub, 10 = funct decode):
- FETCH (0): `adr_src`=0, `ir_write`=1, A=00, B=10, `aluop`=00, `result_src`=10, `pc_write`=1. Next: DECODE.
- DECODE (1): A=01, B=01, `aluop`=00. Next by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other value → ILLEGAL
- MEMADR (2): A=10, B=01, `aluop`=00. Next: MEMREAD if `op`=0000011, else MEMWRITE.
- MEMREAD (3): `adr_src`=1, `result_src`=00. Next: MEMWB.
- MEMWB (4): `result_src`=01, `reg_write`=1. Next: FETCH.
- MEMWRITE (5): `adr_src`=1, `result_src`=00, `mem_write`=1. Next: FETCH.
- EXECUTER (6): A=10, B=00, `aluop`=10. Next: ALUWB.
- EXECUTEI (7): A=10, B=01, `aluop`=10. Next: ALUWB.
- ALUWB (8): `result_src`=00, `reg_write`=1. Next: FETCH.
- BEQ (9): A=10, B=00, `aluop`=01, `result_src`=00; `pc_write` = `zero`. Next: FETCH.
- JAL (10): A=01, B=10, `aluop`=00, `result_src`=00, `pc_write`=1. Next: ALUWB.
- ILLEGAL (11): all enables 0, `illegal`=1. Stays until reset.
- Encodings 12–15: unreachable; treated as ILLEGAL.

ALU decode:
- `aluop`=00 → add; `aluop`=01 → sub.
- `aluop`=10, by `funct3`:
  - 000 → sub if (`op`[5] & `funct7b5`), else add.
  - 010 → slt.
  - 110 → or.
  - 111 → and.
  - any other value → add.
- `aluop`=11 → add.

Immediate decode (combinational from `op`, independent of state):
- 0100011 → S
- 1100011 → B
- 1101111 → J
- all others → I

## Timing
- Outputs are a pure function of state plus (`op`, `funct3`, `funct7b5`, `zero`). No output registers; decode settles in the same cycle as the state.
- Cycles per instruction, FETCH to the next FETCH: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4.
- Reset:
  - `rst_n` low forces state to FETCH immediately (asynchronous).
  - While `rst_n` is low, `pc_write`, `ir_write`, `mem_write` and `reg_write` are combinationally forced to 0.
  - Mux selects and `alu_control` during reset show the FETCH values. `illegal`=0.
  - The first fetch occurs on the first rising edge after `rst_n` goes high.
- Reset mid-instruction (e.g. in MEMWRITE): `mem_write` drops immediately and state returns to FETCH. No partial write is committed on the following edge.
- `op` must be stable from the edge that leaves FETCH until the instruction completes. The IR is loaded only in FETCH, which guarantees this.

## Structure
- Shared package `mc_pkg` holds:
  - state encodings
  - `aluop`, `alu_control`, `result_src`, `alu_src_a`/`alu_src_b`, `imm_src` encodings
  - opcode constants
- One natural sub-module: `alu_dec`, combinational (`aluop`, `funct3`, `funct7b5`, `op`[5] → `alu_control`).
- FSM next-state logic, output decode and immediate decode live in `mc_controller`.

## Test plan
1. Reset/release: hold `rst_n`=0 for 3 cycles with `op`=0110011 → `state`=0, all four enables 0. Release → the first edge loads IR (`ir_write`=1, `pc_write`=1 in that cycle), `state`=1 next.
2. lw, `op`=0000011 → states 0, 1, 2, 3, 4, 0 (5 cycles). `adr_src`=1 only in state 3; `reg_write`=1 with `result_src`=01 only in state 4.
3. sw, `op`=0100011 → states 0, 1, 2, 5, 0. `mem_write`=1 for exactly 1 cycle with `adr_src`=1; `imm_src`=01. Assert `rst_n`=0 while in state 5 → `mem_write`=0 immediately, `state`=0.
4. R-type sub, `op`=0110011, `funct3`=000, `funct7b5`=1 → in state 6 `alu_control`=001. Same fields with `op`=0010011 (addi) → state 7 gives 000. `funct3`=111 → 010; `funct3`=010 → 101.
5. beq, `op`=1100011 → states 0, 1, 9, 0. With `zero`=1, `pc_write`=1 in state 9; with `zero`=0, `pc_write`=0. `alu_control`=001 in state 9.
6. jal, `op`=1101111 → states 0, 1, 10, 8, 0, with `pc_write`=1 in state 10 and `reg_write`=1 in state 8. Then `op`=1111111 → state 11, `illegal`=1, held for 10 cycles until reset.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle RV32I controller
package mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
  } state_t;
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_DEC = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
endpackage

// File: rtl/mc_controller_alu_dec.sv
// alu_dec: maps aluop and instruction function fields to the ALU operation
module alu_dec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);
  logic [2:0] dec;
  always_comb begin
    dec = funct3 == 3'b000 ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
          funct3 == 3'b010 ? ALU_SLT :
          funct3 == 3'b110 ? ALU_OR  :
          funct3 == 3'b111 ? ALU_AND : ALU_ADD;
    alu_control = aluop == ALUOP_SUB ? ALU_SUB :
                  aluop == ALUOP_DEC ? dec : ALU_ADD;
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I control FSM with combinational output decode
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic [3:0] state
);
  state_t st, nx;
  logic [1:0] aluop;
  logic pcw, mw, irw, rw;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= S_FETCH;
    else st <= nx;
  always_comb begin
    case (st)
      S_FETCH:    nx = S_DECODE;
      S_DECODE:   nx = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                       op == OP_R   ? S_EXECUTER :
                       op == OP_I   ? S_EXECUTEI :
                       op == OP_BEQ ? S_BEQ :
                       op == OP_JAL ? S_JAL : S_ILLEGAL;
      S_MEMADR:   nx = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nx = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: nx = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: nx = S_FETCH;
      default:    nx = S_ILLEGAL;
    endcase
  end
  always_comb begin
    pcw = 1'b0;
    mw = 1'b0;
    irw = 1'b0;
    rw = 1'b0;
    adr_src = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_RD2;
    aluop = ALUOP_ADD;
    illegal = 1'b0;
    case (st)
      S_FETCH:    begin irw = 1'b1; pcw = 1'b1; alu_src_b = SRCB_4; result_src = RES_ALU; end
      S_DECODE:   begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; end
      S_MEMADR:   begin alu_src_a = SRCA_RD1; alu_src_b = SRCB_IMM; end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB:    begin result_src = RES_MEM; rw = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; mw = 1'b1; end
      S_EXECUTER: begin alu_src_a = SRCA_RD1; aluop = ALUOP_DEC; end
      S_EXECUTEI: begin alu_src_a = SRCA_RD1; alu_src_b = SRCB_IMM; aluop = ALUOP_DEC; end
      S_ALUWB:    rw = 1'b1;
      S_BEQ:      begin alu_src_a = SRCA_RD1; aluop = ALUOP_SUB; pcw = zero; end
      S_JAL:      begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_4; pcw = 1'b1; end
      default:    illegal = 1'b1;
    endcase
  end
  // enables are gated by rst_n so nothing commits on the edge after a mid-instruction reset
  assign pc_write  = pcw & rst_n;
  assign mem_write = mw & rst_n;
  assign ir_write  = irw & rst_n;
  assign reg_write = rw & rst_n;
  assign state = st;
  assign imm_src = op == OP_SW  ? IMM_S :
                   op == OP_BEQ ? IMM_B :
                   op == OP_JAL ? IMM_J : IMM_I;
  alu_dec u_alu_dec (
    .aluop(aluop),
    .funct3(funct3),
    .funct7b5(funct7b5),
    .op5(op[5]),
    .alu_control(alu_control)
  );
endmodule
